// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Holds the FSM encoding, sweep geometry and the reference table.
package tt_check_pkg;

    localparam int N_VEC = 16;
    localparam int VEC_W = 4;

    // F = A(CD+B) + BC', bit i = F for {A,B,C,D} = i
    localparam logic [N_VEC-1:0] F_EXPECTED = 16'hF830;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SAMPLE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter used to hold each vector before sampling.
// Saturates at zero; load has priority over en.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive 4-input truth-table sweeper and comparator.
// Optional STOP_ON_ERR_EN ends the sweep at the first mismatch.
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter logic [N_VEC-1:0] EXPECTED      = F_EXPECTED,
    parameter int               SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [VEC_W-1:0] vec_out,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] table_out,
    output logic [4:0]       mismatch_cnt,
    output logic [VEC_W-1:0] first_err_idx,
    output logic             err_valid
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [N_VEC-1:0] table_q, table_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [VEC_W-1:0] first_q, first_d;
    logic             errv_q, errv_d;
    logic             pass_q, pass_d;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_zero;
    logic             miss;
    logic             stop;

    settle_timer #(.W(VEC_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (VEC_W'(SETTLE_CYCLES)),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        table_d  = table_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        errv_d   = errv_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        miss     = 1'b0;
        stop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                vec_d = '0;
                if (start) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    table_d  = '0;
                    cnt_d    = '0;
                    first_d  = '0;
                    errv_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            ST_HOLD: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                table_d[vec_q] = f_in;
                miss = (f_in != EXPECTED[vec_q]);
                if (miss) begin
                    cnt_d = cnt_q + 5'd1;
                    if (!errv_q) begin
                        first_d = vec_q;
                        errv_d  = 1'b1;
                    end
                end
`ifdef STOP_ON_ERR_EN
                stop = miss;
`else
                stop = 1'b0;
`endif
                if (stop || (vec_q == VEC_W'(N_VEC - 1))) begin
                    state_d = ST_DONE;
                    pass_d  = (cnt_d == '0);
                end else begin
                    state_d  = ST_HOLD;
                    vec_d    = vec_q + 1'b1;
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            table_q <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            errv_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            errv_q  <= errv_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out       = vec_q;
    assign busy          = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign table_out     = table_q;
    assign mismatch_cnt  = cnt_q;
    assign first_err_idx = first_q;
    assign err_valid     = errv_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker with a faultable gate model.
// Build with STOP_ON_ERR_EN to match an early-stop DUT.
module tb_tt_sweep_checker;

    localparam int SETTLE = 2;
    localparam int PER_V  = SETTLE + 2;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic [3:0]  idx;
        logic        errv;
        logic        pass;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_err_idx;
    logic        err_valid;

    int   mode;
    int   total;
    int   bad;
    exp_t sb[$];

    tt_sweep_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec_out       (vec_out),
        .f_in          (f_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .table_out     (table_out),
        .mismatch_cnt  (mismatch_cnt),
        .first_err_idx (first_err_idx),
        .err_valid     (err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_f(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (a & ((c & d) | b)) | (b & ~c);
    endfunction

    // mode 0: good, 1: stuck-at-0, 2: entry 11 inverted
    function automatic logic model_f(input logic [3:0] v, input int m);
        logic f;
        f = ref_f(v);
        if (m == 1) f = 1'b0;
        if (m == 2 && v == 4'd11) f = ~f;
        return f;
    endfunction

    always_comb f_in = model_f(vec_out, mode);

    function automatic exp_t predict(input int m);
        exp_t e;
        logic [3:0] v;
        int last;
        e.tbl = '0;
        e.cnt = '0;
        e.idx = '0;
        e.errv = 1'b0;
        last = 15;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            e.tbl[i] = model_f(v, m);
            if (model_f(v, m) != ref_f(v)) begin
                e.cnt = e.cnt + 5'd1;
                if (!e.errv) begin
                    e.idx = v;
                    e.errv = 1'b1;
                end
`ifdef STOP_ON_ERR_EN
                last = i;
                break;
`endif
            end
        end
        e.pass = (e.cnt == 0);
        e.cycles = (last + 1) * PER_V;
        return e;
    endfunction

    task automatic run_sweep(input string nm, input int m, input int poke_vec);
        exp_t e;
        int n;
        int pulses;
        mode = m;
        sb.push_back(predict(m));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start got=%b want=1", nm, busy);
        end
        n = 0;
        while (!done && n < 400) begin
            if (poke_vec >= 0 && vec_out == 4'(poke_vec)) begin
                start = 1'b1;
                poke_vec = -1;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        e = sb.pop_front();
        total++;
        if (!done || n != e.cycles) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", nm, n, e.cycles);
        end
        total++;
        if (table_out !== e.tbl) begin
            bad++;
            $display("FAIL %s table got=%h want=%h", nm, table_out, e.tbl);
        end
        total++;
        if (mismatch_cnt !== e.cnt) begin
            bad++;
            $display("FAIL %s cnt got=%0d want=%0d", nm, mismatch_cnt, e.cnt);
        end
        total++;
        if (first_err_idx !== e.idx || err_valid !== e.errv) begin
            bad++;
            $display("FAIL %s first_err got=%0d/%b want=%0d/%b", nm,
                     first_err_idx, err_valid, e.idx, e.errv);
        end
        total++;
        if (pass !== e.pass || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s pass/busy got=%b/%b want=%b/0", nm, pass, busy, e.pass);
        end
        pulses = 0;
        for (int k = 0; k < 2 * PER_V; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0 || busy !== 1'b0 || pass !== e.pass || table_out !== e.tbl
            || vec_out !== 4'd0) begin
            bad++;
            $display("FAIL %s idle_hold pulses=%0d busy=%b pass=%b tbl=%h vec=%0d",
                     nm, pulses, busy, pass, table_out, vec_out);
        end
    endtask

    task automatic check_zero(input string nm);
        total++;
        if (vec_out !== 0 || busy !== 0 || done !== 0 || pass !== 0 || table_out !== 0
            || mismatch_cnt !== 0 || first_err_idx !== 0 || err_valid !== 0) begin
            bad++;
            $display("FAIL %s got vec=%0d busy=%b done=%b pass=%b tbl=%h cnt=%0d idx=%0d ev=%b want all 0",
                     nm, vec_out, busy, done, pass, table_out, mismatch_cnt,
                     first_err_idx, err_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
    endtask

    task automatic test_good();
        run_sweep("good", 0, -1);
    endtask

    task automatic test_stuck0();
        run_sweep("stuck0", 1, -1);
    endtask

    task automatic test_bit11();
        run_sweep("bit11", 2, -1);
    endtask

    task automatic test_mid_reset();
        int n;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vec_out != 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (vec_out !== 4'd7) begin
            bad++;
            $display("FAIL mid_reset reach_v7 got=%0d want=7", vec_out);
        end
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        run_sweep("after_reset", 0, -1);
    endtask

    task automatic test_start_while_busy();
        run_sweep("busy_start", 0, 3);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        mode = 0;
        test_reset();
        test_good();
        test_stuck0();
        test_bit11();
        test_mid_reset();
        test_start_while_busy();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
